tl45_prefetch: RTL and testbench

- Parametrised instruction fetch stage that replaces the hard-wired no-fetch stub.
- Acts as a Wishbone B4 pipelined read master and issues one outstanding word read at a time.
- Fetched words go into a DEPTH-entry prefetch FIFO; the FIFO head is presented to decode as {pc, inst, err} with a valid flag.
- Supports PC redirect with a full flush and in-flight bus abort. Bus errors are reported as tagged entries.

---
 rtl/tl45_pkg.sv | 20 ++
 rtl/tl45_prefetch_if.sv | 25 ++
 rtl/tl45_sync_fifo.sv | 55 +++++
 rtl/tl45_prefetch.sv | 125 ++++++++++++
 tb/tb_tl45_prefetch.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl45_pkg.sv
// Shared types for the TL45 front end: fetch entries, fetch FSM states and
// the instruction word used for error entries.
package tl45_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HALT
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/tl45_prefetch_if.sv
// Wishbone B4 pipelined read-only bus between the prefetch master and memory.
// Handshake: the master raises cyc+stb with addr and holds them while stall is
// high; the request is accepted on the first edge with stb && !stall. Exactly one
// ack or err then ends it while cyc is still high; dropping cyc aborts the request.
interface tl45_prefetch_if #(
    parameter int AW = 30
);
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic [AW-1:0] o_wb_addr;
    logic          i_wb_stall;
    logic          i_wb_ack;
    logic          i_wb_err;
    logic [31:0]   i_wb_data;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_addr,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_addr,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );
endinterface

// File: rtl/tl45_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// A push while full is accepted only when a pop happens in the same cycle.
module tl45_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[PW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[PW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl45_prefetch.sv
// Instruction fetch stage: single-outstanding Wishbone read master feeding a
// prefetch FIFO whose head is presented to decode, with redirect flush/abort.
module tl45_prefetch
    import tl45_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          AW       = 30
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pipe_stall,
    input  logic                 i_new_pc,
    input  logic [31:0]          i_pc,
    tl45_prefetch_if.master      wb,
    output logic                 o_buf_valid,
    output logic [31:0]          o_buf_pc,
    output logic [31:0]          o_buf_inst,
    output logic                 o_buf_err,
    output fetch_state_t         o_dbg_state
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state, state_d;
    logic [31:0]   fetch_pc, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          push, pop, flush;
    fetch_entry_t  push_entry, head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          outstanding;
    logic [CW:0]   occupancy;
    logic          room;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^i_pc[1:0];

    tl45_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .din     (push_entry),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // An in-flight request reserves a slot, so its ack always finds room.
    assign outstanding = (state == REQ) || (state == WAIT);
    assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding};
    assign room        = !fifo_full && (occupancy < (CW+1)'(DEPTH));

    assign o_buf_valid = !fifo_empty;
    assign o_buf_pc    = head.pc;
    assign o_buf_inst  = head.inst;
    assign o_buf_err   = head.err;
    assign pop         = o_buf_valid && !i_pipe_stall;

    assign wb.o_wb_cyc  = outstanding;
    assign wb.o_wb_stb  = (state == REQ);
    assign wb.o_wb_addr = addr_q;
    assign o_dbg_state  = state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= '0;
        end else begin
            state    <= state_d;
            fetch_pc <= pc_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = fetch_pc;
        addr_d     = addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        push_entry = '0;
        if (i_new_pc) begin
            // Redirect wins over everything; a response landing now is dropped.
            flush   = 1'b1;
            state_d = IDLE;
            pc_d    = {i_pc[31:2], 2'b00};
        end else begin
            case (state)
                IDLE: begin
                    if (room) begin
                        state_d = REQ;
                        addr_d  = fetch_pc[AW+1:2];
                    end
                end
                REQ, WAIT: begin
                    // In REQ a response only counts once the strobe is accepted.
                    if ((state == WAIT) || !wb.i_wb_stall) begin
                        if (wb.i_wb_ack) begin
                            push       = 1'b1;
                            push_entry = '{pc: fetch_pc, inst: wb.i_wb_data, err: 1'b0};
                            pc_d       = fetch_pc + 32'd4;
                            state_d    = IDLE;
                        end else if (wb.i_wb_err) begin
                            push       = 1'b1;
                            push_entry = '{pc: fetch_pc, inst: NOP_INST, err: 1'b1};
                            state_d    = HALT;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                HALT: state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl45_prefetch.sv
// Directed bench for tl45_prefetch: behavioural Wishbone memory plus an
// expected-entry queue checked at the decode side.
module tb_tl45_prefetch;
    import tl45_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 30;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pipe_stall = 1'b1;
    logic         new_pc = 1'b0;
    logic [31:0]  pc_in = 32'h0;
    logic         buf_valid;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_inst;
    logic         buf_err;
    fetch_state_t dbg_state;

    tl45_prefetch_if #(.AW(AW)) wb ();

    tl45_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .AW       (AW)
    ) u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_pipe_stall (pipe_stall),
        .i_new_pc     (new_pc),
        .i_pc         (pc_in),
        .wb           (wb),
        .o_buf_valid  (buf_valid),
        .o_buf_pc     (buf_pc),
        .o_buf_inst   (buf_inst),
        .o_buf_err    (buf_err),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- memory slave model ----------------
    int            stall_cycles = 0;
    int            wait_cycles  = 0;
    logic          err_en       = 1'b0;
    logic [AW-1:0] err_addr     = '0;
    int            stall_cnt    = 0;
    int            pend_cnt     = -1;
    logic [AW-1:0] lat_addr     = '0;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        case (a)
            30'd0:   mem_word = 32'h0d10_0001;
            30'd1:   mem_word = 32'h0811_1000;
            default: mem_word = 32'hC000_0000 ^ {a, 2'b00};
        endcase
    endfunction

    always @(negedge clk) begin
        wb.i_wb_ack  = 1'b0;
        wb.i_wb_err  = 1'b0;
        wb.i_wb_data = 32'h0;
        wb.i_wb_stall = 1'b0;
        if (!wb.o_wb_cyc) begin
            pend_cnt  = -1;
            stall_cnt = 0;
        end else if (pend_cnt == 0) begin
            if (err_en && lat_addr == err_addr) begin
                wb.i_wb_err = 1'b1;
            end else begin
                wb.i_wb_ack  = 1'b1;
                wb.i_wb_data = mem_word(lat_addr);
            end
            pend_cnt = -1;
        end else if (pend_cnt > 0) begin
            pend_cnt--;
        end
        if (wb.o_wb_cyc && wb.o_wb_stb) begin
            if (stall_cnt < stall_cycles) begin
                wb.i_wb_stall = 1'b1;
                stall_cnt++;
            end else begin
                stall_cnt = 0;
                pend_cnt  = wait_cycles;
                lat_addr  = wb.o_wb_addr;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [64:0] exp_q[$];

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst, input logic err);
        exp_q.push_back({pc, inst, err});
    endtask

    // Pops n entries from decode's side, comparing each to the expected queue.
    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            int budget = 0;
            logic [64:0] exp;
            while (!buf_valid && budget < 100) begin
                tick();
                budget++;
            end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
            if (!buf_valid) begin
                check("drain_timeout", 65'(buf_valid), 65'd1);
            end else begin
                check($sformatf("entry_pc_%h", exp[64:33]), {buf_pc, buf_inst, buf_err}, exp);
                pipe_stall = 1'b0;
                tick();
                pipe_stall = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        new_pc = 1'b0;
        pipe_stall = 1'b1;
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic wait_stb(input string tag);
        int budget = 0;
        while (!wb.o_wb_stb && budget < 100) begin
            tick();
            budget++;
        end
        if (!wb.o_wb_stb) check(tag, 65'(wb.o_wb_stb), 65'd1);
    endtask

    task automatic wait_count(input string tag, input int n);
        int budget = 0;
        while (int'(u_dut.u_fifo.count) < n && budget < 100) begin
            tick();
            budget++;
        end
        check(tag, 65'(u_dut.u_fifo.count), 65'(n));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int nreq;
        int ncyc;

        // Reset state and first fetches from a zero-wait memory.
        do_reset();
        check("rst_cyc",   65'(wb.o_wb_cyc),  65'd0);
        check("rst_stb",   65'(wb.o_wb_stb),  65'd0);
        check("rst_addr",  65'(wb.o_wb_addr), 65'd0);
        check("rst_valid", 65'(buf_valid),    65'd0);
        check("rst_pc",    65'(buf_pc),       65'd0);
        check("rst_inst",  65'(buf_inst),     65'd0);
        check("rst_err",   65'(buf_err),      65'd0);
        check("rst_state", 65'(dbg_state),    65'(IDLE));
        rst = 1'b0;
        tick();
        check("first_stb",  65'(wb.o_wb_stb),  65'd1);
        check("first_addr", 65'(wb.o_wb_addr), 65'd0);
        tick();
        check("lat_not_yet", 65'(buf_valid), 65'd0);
        tick();
        check("lat_visible", 65'(buf_valid), 65'd1);
        expect_entry(32'h0, 32'h0d10_0001, 1'b0);
        expect_entry(32'h4, 32'h0811_1000, 1'b0);
        drain(2);

        // Decode stalled: the FIFO fills to DEPTH and the bus goes quiet.
        do_reset();
        rst = 1'b0;
        nreq = 0;
        repeat (20) begin
            tick();
            if (wb.o_wb_stb) nreq++;
        end
        check("fill_requests", 65'(nreq), 65'd4);
        check("fill_cyc_idle", 65'(wb.o_wb_cyc), 65'd0);
        check("fill_count", 65'(u_dut.u_fifo.count), 65'd4);
        wait_cycles = 2;
        expect_entry(32'h0, 32'h0d10_0001, 1'b0);
        drain(1);
        // Pop the head in the same cycle the pc=16 ack lands.
        begin
            int budget = 0;
            @(negedge clk);
            #1;
            while (!wb.i_wb_ack && budget < 50) begin
                @(negedge clk);
                #1;
                budget++;
            end
        end
        check("pushpop_ack", 65'(wb.i_wb_ack), 65'd1);
        check("pushpop_pre_count", 65'(u_dut.u_fifo.count), 65'd3);
        check("pushpop_head", 65'(buf_pc), 65'h4);
        pipe_stall = 1'b0;
        @(posedge clk);
        #1;
        pipe_stall = 1'b1;
        wait_cycles = 0;
        check("pushpop_post_count", 65'(u_dut.u_fifo.count), 65'd3);
        expect_entry(32'h8,  mem_word(30'd2), 1'b0);
        expect_entry(32'hC,  mem_word(30'd3), 1'b0);
        expect_entry(32'h10, mem_word(30'd4), 1'b0);
        expect_entry(32'h14, mem_word(30'd5), 1'b0);
        drain(4);

        // Slave stalls the strobe for three cycles.
        do_reset();
        stall_cycles = 3;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_stb_%0d", i),  65'(wb.o_wb_stb),  65'd1);
            check($sformatf("stall_addr_%0d", i), 65'(wb.o_wb_addr), 65'd0);
            tick();
        end
        check("stall_released", 65'(wb.o_wb_stb), 65'd0);
        stall_cycles = 0;
        expect_entry(32'h0, 32'h0d10_0001, 1'b0);
        drain(1);

        // Redirect while WAIT with two buffered entries; the late ack is dropped.
        do_reset();
        wait_cycles = 1;
        rst = 1'b0;
        wait_count("redir_two_buffered", 2);
        wait_stb("redir_stb_timeout");
        tick();
        tick();
        check("redir_in_wait", 65'(dbg_state), 65'(WAIT));
        new_pc = 1'b1;
        pc_in  = 32'h0000_0103;
        tick();
        new_pc = 1'b0;
        check("redir_valid", 65'(buf_valid), 65'd0);
        check("redir_cyc",   65'(wb.o_wb_cyc), 65'd0);
        check("redir_count", 65'(u_dut.u_fifo.count), 65'd0);
        wait_cycles = 0;
        tick();
        check("redir_stb",  65'(wb.o_wb_stb),  65'd1);
        check("redir_addr", 65'(wb.o_wb_addr), 65'h40);
        expect_entry(32'h100, mem_word(30'h40), 1'b0);
        expect_entry(32'h104, mem_word(30'h41), 1'b0);
        drain(2);

        // Bus error on pc=8: tagged entry, then halt until a redirect.
        do_reset();
        err_en   = 1'b1;
        err_addr = 30'd2;
        rst = 1'b0;
        repeat (20) tick();
        check("err_cyc_quiet", 65'(wb.o_wb_cyc), 65'd0);
        check("err_state",     65'(dbg_state),   65'(HALT));
        check("err_count",     65'(u_dut.u_fifo.count), 65'd3);
        expect_entry(32'h0, 32'h0d10_0001, 1'b0);
        expect_entry(32'h4, 32'h0811_1000, 1'b0);
        expect_entry(32'h8, 32'h0, 1'b1);
        drain(3);
        ncyc = 0;
        repeat (10) begin
            tick();
            if (wb.o_wb_cyc) ncyc++;
        end
        check("halt_no_cyc", 65'(ncyc), 65'd0);
        err_en = 1'b0;
        new_pc = 1'b1;
        pc_in  = 32'h0;
        tick();
        new_pc = 1'b0;
        expect_entry(32'h0, 32'h0d10_0001, 1'b0);
        drain(1);

        // PC wraps from the top of the address space back to zero.
        new_pc = 1'b1;
        pc_in  = 32'hFFFF_FFFE;
        tick();
        new_pc = 1'b0;
        expect_entry(32'hFFFF_FFFC, mem_word(30'h3FFF_FFFF), 1'b0);
        expect_entry(32'h0, 32'h0d10_0001, 1'b0);
        drain(2);

        // Reset while a slow request sits in WAIT.
        wait_cycles = 3;
        wait_count("rstwait_buffered", 1);
        wait_stb("rstwait_stb_timeout");
        tick();
        check("rstwait_cyc_before", 65'(wb.o_wb_cyc), 65'd1);
        rst = 1'b1;
        tick();
        check("rstwait_cyc",   65'(wb.o_wb_cyc), 65'd0);
        check("rstwait_valid", 65'(buf_valid),   65'd0);
        rst = 1'b0;
        wait_cycles = 0;
        exp_q.delete();
        tick();
        check("rstwait_stb",  65'(wb.o_wb_stb),  65'd1);
        check("rstwait_addr", 65'(wb.o_wb_addr), 65'd0);
        expect_entry(32'h0, 32'h0d10_0001, 1'b0);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
